alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports: clk in 1 (rising-edge clock), rst_n in 1 (async active-low reset).
REQ-002 SHALL have: instr_valid in 1 (instruction offered); instr_ready out 1 (controller can accept); instr in 32 (MIPS instruction word); rs_val in 32, rt_val in 32 (register operands).
REQ-003 SHALL drive the ALU: alu_op out 5; alu_a out 32; alu_b out 32; SHALL receive alu_out in 32 and flag in 1.
REQ-004 SHALL output: res_valid out 1; res_ready in 1; res_data out 32; res_rd out 5 (destination register); res_wr out 1 (write-back enable); br_taken out 1; illegal out 1.

Function
REQ-005 SHALL implement FSM states IDLE, EXEC, DONE; instr_ready=1 only in IDLE; res_valid=1 only in DONE.
REQ-006 IDLE: on instr_valid=1 at a rising edge, SHALL latch instr, rs_val, rt_val and decoded fields, then go to EXEC (legal) or DONE (illegal).
REQ-007 EXEC lasts exactly one cycle; alu_op/alu_a/alu_b SHALL be registered outputs stable for the whole EXEC cycle; at the EXEC-ending edge, SHALL capture alu_out into res_data and flag into br_taken, then go to DONE.
REQ-008 DONE SHALL hold all result outputs stable until res_ready=1 at a rising edge, then return to IDLE; a new instruction is not accepted in that same cycle.
REQ-009 Latency: accept at edge N, res_valid high from edge N+2; minimum 3 cycles per instruction.
REQ-010 Outside EXEC, alu_op, alu_a, alu_b SHALL be 0.
REQ-011 R-type (opcode 0x00), dest=rd, a=rs_val, b=rt_val: funct 0x20/0x21 -> op 0x01; 0x22/0x23 -> 0x02; 0x24 -> 0x03; 0x25 -> 0x04; 0x26 -> 0x05; 0x27 -> 0x06.
REQ-012 Shifts, dest=rd, a=rt_val: funct 0x00/0x02/0x03 (sll/srl/sra) -> op 0x0D/0x0E/0x0F, b={27'b0,shamt}; funct 0x04/0x06/0x07 (sllv/srlv/srav) -> same ops, b={27'b0,rs_val[4:0]}.
REQ-013 Opcode 0x1C, dest=rd, a=rs_val, b=0: funct 0x20 (clz) -> op 0x1F; funct 0x21 (clo) -> op 0x1E.
REQ-014 I-type, dest=rt, a=rs_val: 0x08/0x09 -> op 0x01, b=sign-extended imm; 0x0C/0x0D/0x0E -> op 0x03/0x04/0x05, b=zero-extended imm; 0x0F (lui) -> op 0x10, a=0, b={16'b0,imm}.
REQ-015 Branches, res_wr=0, a=rs_val: 0x04 -> op 0x0B, b=rt_val; 0x05 -> 0x0C, b=rt_val; 0x06 -> 0x0A; 0x07 -> 0x07; opcode 0x01 with rt=0 -> 0x09, rt=1 -> 0x08; b=0 for the last four.
REQ-016 br_taken SHALL be 1 only for branch instructions with flag=1; for non-branches br_taken=0 regardless of flag.
REQ-017 res_wr SHALL be 1 for legal non-branch instructions with destination != 0; destination 0 -> res_wr=0, res_data still captured.
REQ-018 Any other opcode/funct/rt combination is illegal: skip EXEC, DONE with illegal=1, res_wr=0, br_taken=0, res_data=0, res_rd=0.
REQ-019 illegal SHALL be 0 for legal instructions; all result outputs update only on entry to DONE.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, instr_ready=1 (after deassert), res_valid=0, res_data=0, res_rd=0, res_wr=0, br_taken=0, illegal=0, alu_op=0, alu_a=0, alu_b=0.
REQ-021 Reset asserted in EXEC or DONE SHALL abort the instruction with no result delivered; first post-reset rising edge treats instr_valid as a fresh offer.

Verification
REQ-022 addu rd=3, rs_val=5, rt_val=7, res_ready=1 -> EXEC op 0x01 a=5 b=7; with ALU model: res_valid at N+2, res_data=12, res_rd=3, res_wr=1.
REQ-023 addi imm=0xFFFF, rs_val=1 -> b=0xFFFFFFFF, op 0x01, res_data=0; ori imm=0xFFFF -> b=0x0000FFFF.
REQ-024 beq rs_val=rt_val=9 -> op 0x0B, br_taken=1, res_wr=0; bne same operands -> br_taken=0.
REQ-025 sra shamt=4, rt_val=0x80000000 -> op 0x0F, a=0x80000000, b=4, res_data=0xF8000000; clz rs_val=1 -> op 0x1F, res_data=31.
REQ-026 opcode 0x3F -> no EXEC cycle, res_valid at N+1 with illegal=1; res_ready held 0 for 5 cycles -> outputs stable, instr_ready=0.
REQ-027 rst_n pulled low during EXEC -> all outputs 0 asynchronously, res_valid never asserted for that instruction; next instruction completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue MIPS ALU sequencer: decode, one EXEC cycle, held result
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        flag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_wr,
  output logic        br_taken,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_nxt;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt_f, rd_f, shamt;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  logic [4:0]  dec_op;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_dest;
  logic        dec_branch;
  logic        dec_legal;

  logic        accept;
  logic [4:0]  pend_rd;
  logic        pend_wr;
  logic        pend_branch;

  // Combinational decode of the offered word; only sampled on the accept edge.
  always_comb begin
    dec_op     = 5'h00;
    dec_a      = rs_val;
    dec_b      = rt_val;
    dec_dest   = 5'd0;
    dec_branch = 1'b0;
    dec_legal  = 1'b1;
    case (opcode)
      6'h00: begin
        dec_dest = rd_f;
        case (funct)
          6'h20, 6'h21: dec_op = 5'h01;
          6'h22, 6'h23: dec_op = 5'h02;
          6'h24:        dec_op = 5'h03;
          6'h25:        dec_op = 5'h04;
          6'h26:        dec_op = 5'h05;
          6'h27:        dec_op = 5'h06;
          6'h00, 6'h02, 6'h03: begin
            dec_op = (funct == 6'h00) ? 5'h0D : (funct == 6'h02) ? 5'h0E : 5'h0F;
            dec_a  = rt_val;
            dec_b  = {27'b0, shamt};
          end
          6'h04, 6'h06, 6'h07: begin
            dec_op = (funct == 6'h04) ? 5'h0D : (funct == 6'h06) ? 5'h0E : 5'h0F;
            dec_a  = rt_val;
            dec_b  = {27'b0, rs_val[4:0]};
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h1C: begin
        dec_dest = rd_f;
        dec_b    = 32'h0;
        case (funct)
          6'h20:   dec_op = 5'h1F;
          6'h21:   dec_op = 5'h1E;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        dec_dest = rt_f;
        dec_op   = 5'h01;
        dec_b    = {{16{imm[15]}}, imm};
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_dest = rt_f;
        dec_op   = (opcode == 6'h0C) ? 5'h03 : (opcode == 6'h0D) ? 5'h04 : 5'h05;
        dec_b    = {16'b0, imm};
      end
      6'h0F: begin
        dec_dest = rt_f;
        dec_op   = 5'h10;
        dec_a    = 32'h0;
        dec_b    = {16'b0, imm};
      end
      6'h04, 6'h05: begin
        dec_branch = 1'b1;
        dec_op     = (opcode == 6'h04) ? 5'h0B : 5'h0C;
      end
      6'h06, 6'h07: begin
        dec_branch = 1'b1;
        dec_op     = (opcode == 6'h06) ? 5'h0A : 5'h07;
        dec_b      = 32'h0;
      end
      6'h01: begin
        dec_branch = 1'b1;
        dec_b      = 32'h0;
        case (rt_f)
          5'd0:    dec_op = 5'h09;
          5'd1:    dec_op = 5'h08;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = dec_legal ? EXEC : DONE;
      EXEC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    res_valid   = (state == DONE);
  end

  // ALU drive is registered so it is stable for the whole EXEC cycle and zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= 5'h00;
      alu_a  <= 32'h0;
      alu_b  <= 32'h0;
    end else if (accept && dec_legal) begin
      alu_op <= dec_op;
      alu_a  <= dec_a;
      alu_b  <= dec_b;
    end else if (state == EXEC) begin
      alu_op <= 5'h00;
      alu_a  <= 32'h0;
      alu_b  <= 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rd     <= 5'd0;
      pend_wr     <= 1'b0;
      pend_branch <= 1'b0;
    end else if (accept) begin
      pend_rd     <= dec_branch ? 5'd0 : dec_dest;
      pend_wr     <= dec_legal && !dec_branch && (dec_dest != 5'd0);
      pend_branch <= dec_branch;
    end
  end

  // Result outputs change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= 32'h0;
      res_rd   <= 5'd0;
      res_wr   <= 1'b0;
      br_taken <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && !dec_legal) begin
      res_data <= 32'h0;
      res_rd   <= 5'd0;
      res_wr   <= 1'b0;
      br_taken <= 1'b0;
      illegal  <= 1'b1;
    end else if (state == EXEC) begin
      res_data <= alu_out;
      res_rd   <= pend_rd;
      res_wr   <= pend_wr;
      br_taken <= pend_branch & flag;
      illegal  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr, rs_val, rt_val;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        flag;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_wr, br_taken, illegal;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .flag(flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_wr(res_wr),
    .br_taken(br_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] count_lead(input logic [31:0] v, input logic ones);
    logic [31:0] n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] != ones) break;
      n++;
    end
    return n;
  endfunction

  // Behavioural ALU standing in for the external datapath.
  always_comb begin
    alu_out = 32'h0;
    flag    = 1'b0;
    case (alu_op)
      5'h01: alu_out = alu_a + alu_b;
      5'h02: alu_out = alu_a - alu_b;
      5'h03: alu_out = alu_a & alu_b;
      5'h04: alu_out = alu_a | alu_b;
      5'h05: alu_out = alu_a ^ alu_b;
      5'h06: alu_out = ~(alu_a | alu_b);
      5'h0D: alu_out = alu_a << alu_b[4:0];
      5'h0E: alu_out = alu_a >> alu_b[4:0];
      5'h0F: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      5'h10: alu_out = alu_b << 16;
      5'h1F: alu_out = count_lead(alu_a, 1'b0);
      5'h1E: alu_out = count_lead(alu_a, 1'b1);
      5'h0B: flag = (alu_a == alu_b);
      5'h0C: flag = (alu_a != alu_b);
      5'h0A: flag = ($signed(alu_a) <= 0);
      5'h07: flag = ($signed(alu_a) > 0);
      5'h09: flag = ($signed(alu_a) < 0);
      5'h08: flag = ($signed(alu_a) >= 0);
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Offer one legal instruction with res_ready high and check EXEC drive and result.
  task automatic run_legal(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [4:0] e_op, input logic [31:0] e_a,
                           input logic [31:0] e_b, input logic [31:0] e_data, input logic [4:0] e_rd,
                           input logic e_wr, input logic e_br);
    @(negedge clk);
    instr = ins; rs_val = rs; rt_val = rt; instr_valid = 1'b1; res_ready = 1'b1;
    check({tag, ".ready"}, instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    check({tag, ".op"}, alu_op, e_op);
    check({tag, ".a"}, alu_a, e_a);
    check({tag, ".b"}, alu_b, e_b);
    check({tag, ".exec_valid"}, res_valid, 0);
    @(negedge clk);
    check({tag, ".valid"}, res_valid, 1);
    check({tag, ".data"}, res_data, e_data);
    check({tag, ".rd"}, res_rd, e_rd);
    check({tag, ".wr"}, res_wr, e_wr);
    check({tag, ".br"}, br_taken, e_br);
    check({tag, ".ill"}, illegal, 0);
    check({tag, ".op_done"}, alu_op, 0);
    @(negedge clk);
    check({tag, ".idle"}, instr_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 0; rs_val = 0; rt_val = 0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready", instr_ready, 1);
    check("rst.valid", res_valid, 0);
    check("rst.data", res_data, 0);
    check("rst.op", alu_op, 0);
    check("rst.ill", illegal, 0);
    rst_n = 1'b1;

    // addu $3,$1,$2
    run_legal("addu", 32'h0022_1821, 5, 7, 5'h01, 5, 7, 12, 5'd3, 1'b1, 1'b0);
    // addu $0: data captured, no write-back
    run_legal("addu_r0", 32'h0022_0021, 5, 7, 5'h01, 5, 7, 12, 5'd0, 1'b0, 1'b0);
    // addi $4,$1,-1
    run_legal("addi", 32'h2024_FFFF, 1, 0, 5'h01, 1, 32'hFFFF_FFFF, 0, 5'd4, 1'b1, 1'b0);
    // ori $5,$1,0xFFFF
    run_legal("ori", 32'h3425_FFFF, 32'h1234_0000, 0, 5'h04, 32'h1234_0000, 32'h0000_FFFF,
              32'h1234_FFFF, 5'd5, 1'b1, 1'b0);
    // lui $6,0x1234
    run_legal("lui", 32'h3C06_1234, 32'hDEAD_BEEF, 0, 5'h10, 0, 32'h1234, 32'h1234_0000,
              5'd6, 1'b1, 1'b0);
    // beq / bne with equal operands
    run_legal("beq", 32'h1022_0010, 9, 9, 5'h0B, 9, 9, 0, 5'd0, 1'b0, 1'b1);
    run_legal("bne", 32'h1422_0010, 9, 9, 5'h0C, 9, 9, 0, 5'd0, 1'b0, 1'b0);
    // bltz with negative rs
    run_legal("bltz", 32'h0420_0004, 32'hFFFF_FFF0, 3, 5'h09, 32'hFFFF_FFF0, 0, 0, 5'd0, 1'b0, 1'b1);
    // sra $6,$2,4
    run_legal("sra", 32'h0002_3103, 0, 32'h8000_0000, 5'h0F, 32'h8000_0000, 4,
              32'hF800_0000, 5'd6, 1'b1, 1'b0);
    // sllv $8,$2,$1 with rs_val low bits = 3
    run_legal("sllv", 32'h0022_4004, 32'hFFFF_FFE3, 1, 5'h0D, 1, 3, 8, 5'd8, 1'b1, 1'b0);
    // clz $7,$1
    run_legal("clz", 32'h7020_3820, 1, 32'h55, 5'h1F, 1, 0, 31, 5'd7, 1'b1, 1'b0);

    // Illegal opcode 0x3F: straight to DONE, held while res_ready is low
    @(negedge clk);
    instr = 32'hFC00_0000; rs_val = 32'h1111; rt_val = 32'h2222; instr_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    check("ill.valid", res_valid, 1);
    check("ill.flag", illegal, 1);
    check("ill.op", alu_op, 0);
    check("ill.data", res_data, 0);
    check("ill.wr", res_wr, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("ill.hold%0d", i), {res_valid, illegal, instr_ready, res_wr, br_taken}, 5'b11000);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("ill.release", {res_valid, instr_ready}, 2'b01);

    // Reset asserted mid-EXEC aborts the instruction
    @(negedge clk);
    instr = 32'h0022_1821; rs_val = 5; rt_val = 7; instr_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("abort.exec_op", alu_op, 5'h01);
    #2 rst_n = 1'b0;
    #1;
    check("abort.op", alu_op, 0);
    check("abort.a", alu_a, 0);
    check("abort.valid", res_valid, 0);
    check("abort.data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort.novalid%0d", i), res_valid, 0);
    end
    run_legal("post_rst", 32'h0022_1822, 20, 6, 5'h02, 20, 6, 14, 5'd3, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
